// File: rtl/descriptor_dispatching_pkg.sv
// Shared TSN descriptor definitions: state encodings, queue-entry field split
// and the descriptor record handed to the transmit scheduler.
package descriptor_dispatching_pkg;

  localparam int FIFO_DATA_W = 57;
  localparam int TSNTAG_MSB  = 56;
  localparam int TSNTAG_LSB  = 9;
  localparam int BUFID_MSB   = 8;
  localparam int TSNTAG_W    = TSNTAG_MSB - TSNTAG_LSB + 1;
  localparam int BUFID_W     = BUFID_MSB + 1;
  localparam int PKT_TYPE_W  = 3;
  localparam int STATE_W     = 4;

  localparam logic [STATE_W-1:0] IDLE_ENC     = 4'd0;
  localparam logic [STATE_W-1:0] FIFO_RD_ENC  = 4'd1;
  localparam logic [STATE_W-1:0] CAPTURE_ENC  = 4'd2;
  localparam logic [STATE_W-1:0] WAIT_ACK_ENC = 4'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE_S     = IDLE_ENC,
    FIFO_RD_S  = FIFO_RD_ENC,
    CAPTURE_S  = CAPTURE_ENC,
    WAIT_ACK_S = WAIT_ACK_ENC
  } state_t;

  typedef struct packed {
    logic [TSNTAG_W-1:0]   tsntag;
    logic [BUFID_W-1:0]    bufid;
    logic [PKT_TYPE_W-1:0] pkt_type;
  } descriptor_t;

  // Splits a queue entry {tsntag, bufid} plus its side-band packet type.
  function automatic descriptor_t unpack_entry(input logic [FIFO_DATA_W-1:0] rdata,
                                               input logic [PKT_TYPE_W-1:0]  pkt_type);
    descriptor_t d;
    d.tsntag   = rdata[TSNTAG_MSB:TSNTAG_LSB];
    d.bufid    = rdata[BUFID_MSB:0];
    d.pkt_type = pkt_type;
    return d;
  endfunction

endpackage

// File: rtl/descriptor_dispatching_if.sv
// Queue-FIFO read port and scheduler descriptor port of the dispatcher.
interface descriptor_dispatching_if;
  import descriptor_dispatching_pkg::*;

  logic [FIFO_DATA_W-1:0] iv_fifo_rdata;
  logic [PKT_TYPE_W-1:0]  iv_fifo_pkt_type;
  logic                   i_fifo_empty;
  logic                   o_fifo_rd;

  // Descriptor handshake: o_descriptor_wr is the valid; once raised it and the
  // fields stay frozen until i_descriptor_ack (a one-cycle ready pulse) is
  // sampled high. An ack with no descriptor pending has no effect.
  logic [TSNTAG_W-1:0]    ov_tsntag;
  logic [BUFID_W-1:0]     ov_bufid;
  logic [PKT_TYPE_W-1:0]  ov_pkt_type;
  logic                   o_descriptor_wr;
  logic                   i_descriptor_ack;

  modport master (
    input  iv_fifo_rdata, iv_fifo_pkt_type, i_fifo_empty, i_descriptor_ack,
    output o_fifo_rd, ov_tsntag, ov_bufid, ov_pkt_type, o_descriptor_wr
  );

  modport slave (
    output iv_fifo_rdata, iv_fifo_pkt_type, i_fifo_empty, i_descriptor_ack,
    input  o_fifo_rd, ov_tsntag, ov_bufid, ov_pkt_type, o_descriptor_wr
  );
endinterface

// File: rtl/descriptor_dispatching.sv
// Pulls one entry at a time from the external queue FIFO and presents it as a
// descriptor to the transmit scheduler, counting acknowledged descriptors.
module descriptor_dispatching
  import descriptor_dispatching_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  descriptor_dispatching_if.master dif,
  output logic [CNT_WIDTH-1:0]  ov_dispatch_cnt,
  output logic [STATE_W-1:0]    ov_state
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;
  localparam descriptor_t          DESC_CLEAR = '0;

  state_t               state;
  logic                 rd_q;
  logic                 wr_q;
  descriptor_t          desc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE_S;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      desc_q <= DESC_CLEAR;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE_S: begin
          wr_q   <= 1'b0;
          desc_q <= DESC_CLEAR;
          if (!dif.i_fifo_empty) begin
            rd_q  <= 1'b1;
            state <= FIFO_RD_S;
          end else begin
            rd_q  <= 1'b0;
          end
        end
        FIFO_RD_S: begin
          // FIFO presents the entry during the cycle after the strobe.
          rd_q  <= 1'b0;
          state <= CAPTURE_S;
        end
        CAPTURE_S: begin
          rd_q   <= 1'b0;
          desc_q <= unpack_entry(dif.iv_fifo_rdata, dif.iv_fifo_pkt_type);
          wr_q   <= 1'b1;
          state  <= WAIT_ACK_S;
        end
        WAIT_ACK_S: begin
          rd_q <= 1'b0;
          if (dif.i_descriptor_ack) begin
            wr_q   <= 1'b0;
            desc_q <= DESC_CLEAR;
            cnt_q  <= cnt_q + CNT_ONE;
            state  <= IDLE_S;
          end
        end
        default: begin
          // Corrupted encoding: drop everything but the counter.
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          desc_q <= DESC_CLEAR;
          state  <= IDLE_S;
        end
      endcase
    end
  end

  assign dif.o_fifo_rd       = rd_q;
  assign dif.o_descriptor_wr = wr_q;
  assign dif.ov_tsntag       = desc_q.tsntag;
  assign dif.ov_bufid        = desc_q.bufid;
  assign dif.ov_pkt_type     = desc_q.pkt_type;
  assign ov_dispatch_cnt     = cnt_q;
  assign ov_state            = state;

endmodule
